// File: rtl/piso_pkg.sv
// Shared types and line-level constants for the PISO transmit sequencer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-right (zero fill) register; LSB is the serial output.
module piso_shift_reg #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic         EN,
  input  logic         SHIFT,
  input  logic [N-1:0] DATAW,
  output logic         SOUT
);

  logic [N-1:0] r_sr;

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      r_sr <= '0;
    end else if (EN) begin
      if (SHIFT) r_sr <= {1'b0, r_sr[N-1:1]};
      else       r_sr <= DATAW;
    end
  end

  assign SOUT = r_sr[0];

endmodule

// File: rtl/piso_tx_sequencer.sv
// Frames one word per VALID/READY handshake as start, N data bits LSB first, stop,
// each bit held CLKS_PER_BIT clocks on SOUT.
module piso_tx_sequencer
  import piso_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic [N-1:0] DATA_IN,
  input  logic         VALID,
  output logic         READY,
  output logic         SOUT,
  output logic         BUSY,
  output logic         DONE
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(N - 1);

  tx_state_t       r_state;
  tx_state_t       w_next;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bit;
  logic            r_done;
  logic            w_wrap;
  logic            w_last;
  logic            w_accept;
  logic            w_sr_en;
  logic            w_sr_shift;
  logic            w_sr_out;

  // With CLKS_PER_BIT=1 the counter never leaves 0, so every cycle is a wrap.
  assign w_wrap   = (r_cnt == CNT_MAX);
  assign w_last   = (r_bit == BIT_MAX);
  assign w_accept = VALID && (r_state == IDLE);

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)          w_next = START;
      START:   if (w_wrap)            w_next = DATA;
      DATA:    if (w_wrap && w_last)  w_next = STOP;
      STOP:    if (w_wrap)            w_next = IDLE;
      default:                        w_next = IDLE;
    endcase
  end

  always_comb begin
    READY      = (r_state == IDLE);
    BUSY       = (r_state != IDLE);
    DONE       = r_done;
    w_sr_en    = 1'b0;
    w_sr_shift = 1'b0;
    SOUT       = IDLE_LEVEL;
    case (r_state)
      IDLE: begin
        w_sr_en = w_accept;
        SOUT    = IDLE_LEVEL;
      end
      START: SOUT = START_BIT;
      DATA: begin
        w_sr_en    = w_wrap;
        w_sr_shift = 1'b1;
        SOUT       = w_sr_out;
      end
      STOP:    SOUT = STOP_BIT;
      default: SOUT = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      r_cnt  <= '0;
      r_bit  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == STOP) && w_wrap;
      if (r_state == IDLE || w_wrap) r_cnt <= '0;
      else                           r_cnt <= r_cnt + 1'b1;
      if (r_state == DATA && w_wrap) begin
        if (w_last) r_bit <= '0;
        else        r_bit <= r_bit + 1'b1;
      end
    end
  end

  piso_shift_reg #(.N(N)) u_sr (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .EN      (w_sr_en),
    .SHIFT   (w_sr_shift),
    .DATAW   (DATA_IN),
    .SOUT    (w_sr_out)
  );

endmodule
